fetch_unit: RTL and testbench

- Parametrised decoupled instruction-fetch stage that replaces a single PC register feeding a combinational memory.
- Issues sequential word fetches to a pipelined instruction memory with a valid/ready request channel and an in-order response channel.
- Buffers returned words in a DEPTH-entry circular queue and presents them to decode with a valid/ready handshake.
- Redirect input (branch, BX, pop-to-PC) flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared helpers for the decoupled fetch stage: pointer sizing and fetch stride.
package fetch_unit_pkg;

   // Pointer width for a power-of-two queue depth (at least 1 bit)
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Byte stride between consecutive instruction words
   function automatic int unsigned fetch_incr(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular instruction queue with push, pop and flush; head entry read combinationally.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  logic [WIDTH-1:0]          i_data,
   input  logic                      i_pop,
   input  logic                      i_flush,
   output logic [WIDTH-1:0]          o_data,
   output logic [ptr_w(DEPTH):0]     o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !i_flush && w_push) r_mem[r_tail] <= i_data;
   end

   assign o_data  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, in-order responses, redirect flush.
// Optional counters perf_fetched/perf_flushed/perf_starved when FETCH_UNIT_PERF_EN is defined.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready
`ifdef FETCH_UNIT_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed,
   output logic [31:0]       perf_starved
`endif
);

   localparam int unsigned       PW   = ptr_w(DEPTH);
   localparam int unsigned       CW   = PW + 1;
   localparam int unsigned       SW   = CW + 1;
   localparam logic [ADDR_W-1:0] INCR = ADDR_W'(fetch_incr(DATA_W));

   logic [ADDR_W-1:0]        r_fetch_pc;
   logic [ADDR_W-1:0]        r_resp_pc;
   logic [CW-1:0]            r_outstanding;
   logic [CW-1:0]            r_drop;
   logic [CW-1:0]            w_count;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_accept;
   logic                     w_rsp;
   logic                     w_keep;
   logic                     w_pop;
   logic [ADDR_W-1:0]        w_redirect_pc;
   logic [DATA_W+ADDR_W-1:0] w_head;

   // Thumb bit of the redirect target is discarded
   assign w_redirect_pc = {redirect_pc[ADDR_W-1:1], 1'b0};

   // Credit check: queued plus in-flight words never exceed the queue depth
   assign imem_req  = rst && !redirect_valid &&
                      ((SW'(w_count) + SW'(r_outstanding)) < SW'(DEPTH));
   assign imem_addr = r_fetch_pc;
   assign w_accept  = imem_req && imem_ready;
   assign w_rsp     = imem_rvalid && (r_outstanding != '0);
   assign w_keep    = w_rsp && !redirect_valid && (r_drop == '0);

   assign inst_valid          = rst && !w_empty;
   assign w_pop               = inst_valid && inst_ready;
   assign {inst_data, inst_pc} = w_head;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop        <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
         if (redirect_valid) begin
            // Everything still in flight after this cycle's response is stale
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_drop     <= r_outstanding - CW'(w_rsp);
         end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + INCR;
            if (w_keep)   r_resp_pc  <= r_resp_pc + INCR;
            if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
         end
      end
   end

   fetch_queue #(
      .WIDTH (DATA_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_keep),
      .i_data  ({imem_rdata, r_resp_pc}),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst)
      !(imem_rvalid && (r_outstanding == '0)))
      else $error("fetch_unit: response with no outstanding request");

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(w_keep && w_full && !w_pop))
      else $error("fetch_unit: push into a full queue");

`ifdef FETCH_UNIT_PERF_EN
   logic w_flushed;
   assign w_flushed = w_rsp && !w_keep;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
         perf_starved <= '0;
      end else begin
         if (w_pop && (perf_fetched != '1))     perf_fetched <= perf_fetched + 32'd1;
         if (w_flushed && (perf_flushed != '1)) perf_flushed <= perf_flushed + 32'd1;
         if (!inst_valid && (perf_starved != '1)) perf_starved <= perf_starved + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a pipelined memory model and epoch-based stream model.
module tb_fetch_unit;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] INCR   = 32'd4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
`ifdef FETCH_UNIT_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_starved;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
`ifdef FETCH_UNIT_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed),
      .perf_starved   (perf_starved)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_next;
   logic [31:0] tb_fetch_pc;
   int          tb_queued;
   int          epoch;
   int          cyc;
   int          last_due;
   int          lat_min;
   int          lat_max;
   int          n_fetched;
   int          n_flushed;
   int          n_starved;
   int          pops_total;
   int          checks;
   int          errors;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic restart_stream(input logic [31:0] pc);
      exp_q.delete();
      exp_next = pc;
   endtask

   task automatic refill_stream();
      while (exp_q.size() < 64) begin
         exp_q.push_back(exp_next);
         exp_next += INCR;
      end
   endtask

   // One cycle of stimulus followed by the model update for the edge that follows
   task automatic step(input logic r_rst, input logic r_redir, input logic [31:0] r_pc,
                       input int rdy_pct, input int ird_pct);
      logic acc, popv, stale;
      mreq_t r;
      int due;
      @(negedge clk);
      rst            = r_rst;
      redirect_valid = r_redir;
      redirect_pc    = r_pc;
      imem_ready     = (int'($urandom_range(99)) < rdy_pct);
      inst_ready     = (int'($urandom_range(99)) < ird_pct);
      if (!r_rst) mq.delete();
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mq[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #2;
      acc  = imem_req && imem_ready;
      popv = inst_valid && inst_ready;
      if (!r_rst) begin
         tb_queued   = 0;
         tb_fetch_pc = RST_PC;
         epoch++;
         last_due    = 0;
         n_fetched   = 0;
         n_flushed   = 0;
         n_starved   = 0;
         restart_stream(RST_PC);
      end else begin
         if (imem_rvalid) begin
            r = mq.pop_front();
            stale = (r.epoch != epoch) || r_redir;
            if (stale) n_flushed++;
            else tb_queued++;
         end
         if (popv) begin
            tb_queued--;
            n_fetched++;
            pops_total++;
         end
         if (!inst_valid) n_starved++;
         if (acc) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr  = tb_fetch_pc;
            r.epoch = epoch;
            r.due   = due;
            mq.push_back(r);
            tb_fetch_pc += INCR;
         end
         if (r_redir) begin
            epoch++;
            tb_queued   = 0;
            tb_fetch_pc = r_pc & ~32'd1;
            restart_stream(tb_fetch_pc);
         end
      end
      refill_stream();
      cyc++;
   endtask

   // Monitor: compares DUT outputs against the model state for this cycle
   always @(negedge clk) begin
      logic [31:0] epc;
      logic        exp_req;
      #1;
      exp_req = rst && !redirect_valid && ((mq.size() + tb_queued) < DEPTH);
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (imem_req) chk("imem_addr", imem_addr, tb_fetch_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, rst && (tb_queued != 0)});
      if (rst && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            chk("stream_empty", 32'd1, 32'd0);
         end else begin
            epc = exp_q.pop_front();
            chk("inst_pc", inst_pc, epc);
            chk("inst_data", inst_data, mem_word(epc));
         end
      end
`ifdef FETCH_UNIT_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(n_fetched));
      chk("perf_flushed", perf_flushed, 32'(n_flushed));
      chk("perf_starved", perf_starved, 32'(n_starved));
`endif
   end

   initial begin
      int r;
      int waited;
      logic do_rst, redir;
      checks = 0; errors = 0; cyc = 0; epoch = 0; last_due = 0;
      tb_queued = 0; tb_fetch_pc = RST_PC; pops_total = 0;
      n_fetched = 0; n_flushed = 0; n_starved = 0;
      lat_min = 1; lat_max = 1;
      restart_stream(RST_PC);
      refill_stream();

      repeat (3) step(1'b0, 1'b0, '0, 100, 100);
      // Streaming at latency 1 with no stalls
      repeat (30) step(1'b1, 1'b0, '0, 100, 100);
      // Decode stalled: credits fill the queue, then drain
      repeat (15) step(1'b1, 1'b0, '0, 100, 0);
      repeat (15) step(1'b1, 1'b0, '0, 100, 100);

      // Redirect to an odd target while two latency-3 requests are in flight
      lat_min = 3; lat_max = 3;
      step(1'b0, 1'b0, '0, 100, 100);
      waited = 0;
      while (mq.size() != 2 && waited < 20) begin
         step(1'b1, 1'b0, '0, 100, 100);
         waited++;
      end
      chk("wait_two_outstanding", 32'(mq.size()), 32'd2);
      step(1'b1, 1'b1, 32'h101, 100, 100);
      repeat (20) step(1'b1, 1'b0, '0, 100, 100);

      // Random stalls, redirects, latencies and occasional resets
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1000; i++) begin
         r      = int'($urandom_range(999));
         do_rst = (r < 3);
         redir  = !do_rst && (r < 40);
         step(!do_rst, redir, $urandom & 32'h0000_FFFF, 70, 60);
      end
      // Back-to-back redirects and redirects coinciding with responses and pops
      lat_min = 1; lat_max = 2;
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(99));
         step(1'b1, r < 25, $urandom & 32'h0000_0FFF, 90, 90);
      end
      lat_min = 1; lat_max = 1;
      repeat (40) step(1'b1, 1'b0, '0, 100, 100);

      chk("progress", {31'd0, pops_total > 200}, 32'd1);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
